// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: two-port arbiter and access sequencer for a word-wide data memory
module dmem_port_arbiter #(
  parameter bit PRIO_MODE = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_we,
  input  logic [1:0]  req0_size,
  input  logic        req0_signed,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        rsp0_valid,
  output logic        rsp0_err,
  output logic [31:0] rsp0_rdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_we,
  input  logic [1:0]  req1_size,
  input  logic        req1_signed,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        rsp1_valid,
  output logic        rsp1_err,
  output logic [31:0] rsp1_rdata,
  output logic        mem_wen,
  output logic        mem_ren,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_i,
  input  logic [31:0] mem_data_o
);
  typedef enum logic [2:0] {S_IDLE, S_RD, S_RMW, S_WR, S_RSP} state_t;
  state_t      r_state, w_next;
  logic        r_id, r_we, r_signed, r_err, r_last;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic        w_idle, w_gnt, w_acc, w_err, w_we, w_signed, w_rsp;
  logic [1:0]  w_size;
  logic [31:0] w_addr, w_wdata, w_ext, w_mask, w_merge;
  logic [4:0]  w_bsh;
  logic [15:0] w_lane;

  assign w_idle   = r_state == S_IDLE;
  assign w_gnt    = (req0_valid & req1_valid) ? (PRIO_MODE ? 1'b0 : ~r_last) : req1_valid;
  assign w_acc    = w_idle & (req0_valid | req1_valid);
  assign req0_ready = rst_n & w_idle & req0_valid & ~w_gnt;
  assign req1_ready = rst_n & w_idle & req1_valid & w_gnt;
  assign w_we     = w_gnt ? req1_we : req0_we;
  assign w_size   = w_gnt ? req1_size : req0_size;
  assign w_signed = w_gnt ? req1_signed : req0_signed;
  assign w_addr   = w_gnt ? req1_addr : req0_addr;
  assign w_wdata  = w_gnt ? req1_wdata : req0_wdata;
  assign w_err    = (w_size == 2'b11) | ((w_size == 2'b01) & w_addr[0]) |
                    ((w_size == 2'b10) & (|w_addr[1:0]));

  assign w_bsh   = r_size[0] ? {r_addr[1], 4'b0} : {r_addr[1:0], 3'b0};
  assign w_lane  = 16'(mem_data_o >> w_bsh);
  assign w_ext   = r_size[1] ? mem_data_o :
                   r_size[0] ? {{16{r_signed & w_lane[15]}}, w_lane} :
                               {{24{r_signed & w_lane[7]}}, w_lane[7:0]};
  assign w_mask  = (r_size[0] ? 32'h0000_FFFF : 32'h0000_00FF) << w_bsh;
  assign w_merge = (mem_data_o & ~w_mask) | ((r_wdata << w_bsh) & w_mask);

  // state register; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;

  // next-state: errors skip memory, word stores skip the read half of read-modify-write
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_acc) w_next = w_err ? S_RSP : !w_we ? S_RD : (w_size == 2'b10) ? S_WR : S_RMW;
      S_RD:    w_next = S_RSP;
      S_RMW:   w_next = S_WR;
      S_WR:    w_next = S_RSP;
      S_RSP:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // request latch, load result capture and sub-word merge; r_wdata holds the word to write
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_id     <= 1'b0;
      r_we     <= 1'b0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      r_last   <= 1'b1;
    end else if (w_acc) begin
      r_id     <= w_gnt;
      r_we     <= w_we;
      r_size   <= w_size;
      r_signed <= w_signed;
      r_addr   <= w_addr;
      r_wdata  <= w_wdata;
      r_err    <= w_err;
      r_rdata  <= '0;
      r_last   <= w_gnt;
    end else if (r_state == S_RD) r_rdata <= w_ext;
    else if (r_state == S_RMW) r_wdata <= w_merge;

  assign mem_ren    = (r_state == S_RD) | (r_state == S_RMW);
  assign mem_wen    = rst_n & (r_state == S_WR);
  assign mem_addr   = (mem_ren | (r_state == S_WR)) ? {r_addr[31:2], 2'b00} : '0;
  assign mem_data_i = (r_state == S_WR) ? r_wdata : '0;
  assign w_rsp      = r_state == S_RSP;
  assign rsp0_valid = w_rsp & ~r_id;
  assign rsp1_valid = w_rsp & r_id;
  assign rsp0_err   = rsp0_valid & r_err;
  assign rsp1_err   = rsp1_valid & r_err;
  assign rsp0_rdata = rsp0_valid ? r_rdata : '0;
  assign rsp1_rdata = rsp1_valid ? r_rdata : '0;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed and random checks against a byte-level memory model
module tb_dmem_port_arbiter;
  logic clk = 0, rst_n;
  logic [1:0] rv, rwe, rsg, rdy, rspv, rspe;
  logic [1:0][1:0] rsz;
  logic [1:0][31:0] ra, rwd, rrd;
  logic mem_wen, mem_ren;
  logic [31:0] mem_addr, mem_data_i, mem_data_o;
  logic [1:0] q_rv, q_rdy, q_rspv, q_rspe;
  logic [1:0][31:0] q_rrd;
  logic q_wen, q_ren;
  logic [31:0] q_addr, q_di;
  logic [31:0] wmem [0:63];
  logic [7:0] rb [0:255];
  logic pk_en = 0;
  logic [5:0] pk_idx;
  logic [31:0] pk_val;
  int n_vec = 0, n_err = 0;
  bit m_last;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.PRIO_MODE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(rv[0]), .req0_ready(rdy[0]), .req0_we(rwe[0]), .req0_size(rsz[0]),
    .req0_signed(rsg[0]), .req0_addr(ra[0]), .req0_wdata(rwd[0]),
    .rsp0_valid(rspv[0]), .rsp0_err(rspe[0]), .rsp0_rdata(rrd[0]),
    .req1_valid(rv[1]), .req1_ready(rdy[1]), .req1_we(rwe[1]), .req1_size(rsz[1]),
    .req1_signed(rsg[1]), .req1_addr(ra[1]), .req1_wdata(rwd[1]),
    .rsp1_valid(rspv[1]), .rsp1_err(rspe[1]), .rsp1_rdata(rrd[1]),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr),
    .mem_data_i(mem_data_i), .mem_data_o(mem_data_o));

  dmem_port_arbiter #(.PRIO_MODE(1'b1)) dut_prio (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(q_rv[0]), .req0_ready(q_rdy[0]), .req0_we(1'b0), .req0_size(2'b10),
    .req0_signed(1'b0), .req0_addr(32'h0), .req0_wdata(32'h0),
    .rsp0_valid(q_rspv[0]), .rsp0_err(q_rspe[0]), .rsp0_rdata(q_rrd[0]),
    .req1_valid(q_rv[1]), .req1_ready(q_rdy[1]), .req1_we(1'b0), .req1_size(2'b10),
    .req1_signed(1'b0), .req1_addr(32'h4), .req1_wdata(32'h0),
    .rsp1_valid(q_rspv[1]), .rsp1_err(q_rspe[1]), .rsp1_rdata(q_rrd[1]),
    .mem_wen(q_wen), .mem_ren(q_ren), .mem_addr(q_addr),
    .mem_data_i(q_di), .mem_data_o(32'h0));

  assign mem_data_o = wmem[mem_addr[7:2]];

  always @(negedge clk)
    if (pk_en) wmem[pk_idx] <= pk_val;
    else if (mem_wen) wmem[mem_addr[7:2]] <= mem_data_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    @(posedge clk);
    pk_en = 1; pk_idx = 6'(idx); pk_val = val;
    for (int j = 0; j < 4; j++) rb[4*idx+j] = val[8*j+:8];
    @(posedge clk);
    pk_en = 0;
    @(negedge clk);
  endtask

  task automatic xact(input bit p, input bit we, input logic [1:0] sz, input bit sg,
                      input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
    bit e, other;
    int nb, lat, got, w, ren_n, wen_n;
    logic [31:0] exp_rd;
    logic err_obs;
    e = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    nb = 1 << sz;
    exp_rd = 0;
    if (!e && !we) begin
      for (int i = 0; i < nb; i++) exp_rd |= 32'(rb[8'(a + i)]) << (8 * i);
      if (sg && nb < 4 && exp_rd[8*nb-1]) exp_rd |= ~32'h0 << (8 * nb);
    end
    lat = e ? 1 : (!we || sz == 2'd2) ? 2 : 3;
    rv[p] = 1; rwe[p] = we; rsz[p] = sz; rsg[p] = sg; ra[p] = a; rwd[p] = wd;
    #1;
    w = 0;
    while (!rdy[p] && w < 20) begin @(negedge clk); #1; w++; end
    chk("grant", {30'b0, rdy}, p ? 32'd2 : 32'd1);
    rd = 0;
    if (!rdy[p]) begin rv[p] = 0; return; end
    @(posedge clk);
    m_last = p;
    #1 rv[p] = 0;
    got = 0; ren_n = 0; wen_n = 0; other = 0; err_obs = 0;
    for (int c = 1; c <= 6 && got == 0; c++) begin
      @(negedge clk);
      ren_n += int'(mem_ren);
      wen_n += int'(mem_wen);
      if (rspv[!p]) other = 1;
      if (rspv[p]) begin got = c; err_obs = rspe[p]; rd = rrd[p]; end
    end
    chk("latency", got, lat);
    chk("rsp_err", err_obs, e);
    chk("rsp_rdata", rd, exp_rd);
    chk("ren_cycles", ren_n, (e || (we && sz == 2'd2)) ? 0 : 1);
    chk("wen_cycles", wen_n, (!e && we) ? 1 : 0);
    chk("other_rsp", other, 0);
    if (!e && we) for (int i = 0; i < nb; i++) rb[8'(a + i)] = wd[8*i+:8];
  endtask

  initial begin
    logic [31:0] rd, a;
    logic [1:0] sz;
    int g, r;
    bit seen;
    rst_n = 0; rv = 0; rwe = 0; rsg = 0; rsz = 0; ra = 0; rwd = 0; q_rv = 0;
    repeat (3) @(negedge clk);
    chk("rst_rsp", {rspv, rspe}, 0);
    chk("rst_mem_en", {mem_wen, mem_ren}, 0);
    chk("rst_mem_bus", mem_addr | mem_data_i, 0);
    rv = 2'b11;
    #1 chk("rst_ready", rdy, 0);
    rv = 0;
    @(negedge clk);
    rst_n = 1; m_last = 1;
    for (int i = 0; i < 64; i++) poke(i, $urandom);

    xact(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, rd);
    xact(0, 0, 2'd2, 0, 32'h10, 32'h0, rd);
    chk("t1_word_load", rd, 32'hDEADBEEF);

    poke(8, 32'h11223344);
    xact(1, 1, 2'd0, 0, 32'h22, 32'hAA, rd);
    xact(1, 0, 2'd2, 0, 32'h20, 32'h0, rd);
    chk("t2_rmw_byte", rd, 32'h11AA3344);

    poke(12, 32'h0000F080);
    xact(0, 0, 2'd0, 1, 32'h30, 32'h0, rd);
    chk("t3_byte_signed", rd, 32'hFFFFFF80);
    xact(0, 0, 2'd0, 0, 32'h30, 32'h0, rd);
    chk("t3_byte_unsigned", rd, 32'h00000080);
    xact(1, 0, 2'd1, 1, 32'h30, 32'h0, rd);
    chk("t3_half_signed", rd, 32'hFFFFF080);

    xact(0, 0, 2'd1, 0, 32'h31, 32'h0, rd);
    xact(1, 1, 2'd2, 0, 32'h32, 32'h5555, rd);

    rwe = 0; rsz[0] = 2'd2; rsz[1] = 2'd2; ra[0] = 32'h40; ra[1] = 32'h44; rv = 2'b11;
    g = 0;
    for (int c = 0; c < 60 && g < 4; c++) begin
      @(negedge clk);
      if (rdy != 0) begin
        chk("arb_rr", {30'b0, rdy}, m_last ? 32'd1 : 32'd2);
        m_last = rdy[1];
        g++;
      end
    end
    @(posedge clk);
    #1 rv = 0;
    repeat (4) @(negedge clk);
    chk("arb_rr_grants", g, 4);

    q_rv = 2'b11;
    g = 0;
    for (int c = 0; c < 60 && g < 4; c++) begin
      @(negedge clk);
      if (q_rdy != 0) begin
        chk("arb_prio", {30'b0, q_rdy}, 32'd1);
        g++;
      end
    end
    @(posedge clk);
    #1 q_rv = 0;
    repeat (4) @(negedge clk);
    chk("arb_prio_grants", g, 4);
    chk("arb_prio_rsp1", q_rspv[1] | q_rspe[1] | (|q_rrd[1]), 0);

    poke(20, 32'hCAFEF00D);
    rv[0] = 1; rwe[0] = 1; rsz[0] = 2'd2; ra[0] = 32'h50; rwd[0] = 32'h12345678;
    #1 chk("abort_ready", rdy[0], 1);
    @(posedge clk);
    #1 chk("abort_wen_before", mem_wen, 1);
    rst_n = 0;
    #1 chk("abort_wen_forced", mem_wen, 0);
    chk("abort_ready_forced", rdy, 0);
    seen = 0;
    repeat (3) begin @(negedge clk); if (rspv != 0) seen = 1; end
    chk("abort_no_rsp", seen, 0);
    chk("abort_mem_kept", wmem[20], 32'hCAFEF00D);
    rv = 0; rst_n = 1; m_last = 1;
    @(negedge clk);
    xact(1, 0, 2'd2, 0, 32'h50, 32'h0, rd);
    chk("abort_recover", rd, 32'hCAFEF00D);

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      sz = r < 3 ? 2'd0 : r < 6 ? 2'd1 : r < 9 ? 2'd2 : 2'd3;
      a = $urandom_range(0, 255);
      if ($urandom_range(0, 3) != 0) a = sz == 2'd1 ? a & ~32'd1 : sz == 2'd2 ? a & ~32'd3 : a;
      xact($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, sz, $urandom_range(0, 1) == 1,
           a, $urandom, rd);
    end

    for (int i = 0; i < 64; i++)
      chk("mem_final", wmem[i], {rb[4*i+3], rb[4*i+2], rb[4*i+1], rb[4*i]});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
